// File: rtl/sram_arb_pkg.sv
// Shared constants and FSM state encoding for the two-requester SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned ADR_DEF = 8;
    localparam int unsigned DAT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant decision between two requesters.
// SRAM_ARB_RR_EN selects round-robin on contention; otherwise requester 0 has fixed priority.
module sram_arb_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       win_o
);

`ifdef SRAM_ARB_RR_EN
    // On contention the requester that was not served last wins.
    always_comb begin
        win_o = 1'b0;
        if (req_i == 2'b11) begin
            win_o = ~last_i;
        end else begin
            win_o = req_i[1];
        end
    end
`else
    logic unused_last;
    assign unused_last = last_i;
    assign win_o       = req_i[1] & ~req_i[0];
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter; each transaction walks IDLE -> ACCESS -> RESP.
// Arbitration policy is selected by SRAM_ARB_RR_EN (see sram_arb_pick).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADR = ADR_DEF,
    parameter int unsigned DAT = DAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [2*ADR-1:0] addr,
    input  logic [2*DAT-1:0] wdata,
    output logic [1:0]       ack,
    output logic [DAT-1:0]   rdata,
    output logic             busy,
    output logic             CS,
    output logic             WE,
    output logic             RD,
    output logic [ADR-1:0]   sram_addr,
    output logic [DAT-1:0]   sram_din,
    input  logic [DAT-1:0]   sram_dout
);

    state_e         state_q;
    logic           win_q;
    logic           we_q;
    logic           last_q;
    logic [ADR-1:0] addr_q;
    logic [DAT-1:0] din_q;
    logic [1:0]     ack_q;
    logic           busy_q;
    logic           cs_q;
    logic           wen_q;
    logic           ren_q;
    logic           rd_resp_q;
    logic           win;

    sram_arb_pick u_pick (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (win)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            last_q    <= 1'b1;
            addr_q    <= '0;
            din_q     <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            cs_q      <= 1'b0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            rd_resp_q <= 1'b0;
        end else begin
            ack_q     <= '0;
            rd_resp_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        // Snapshot the winner's request so later input changes are ignored.
                        state_q <= ACCESS;
                        busy_q  <= 1'b1;
                        win_q   <= win;
                        we_q    <= we[win];
                        addr_q  <= win ? addr[ADR +: ADR] : addr[0 +: ADR];
                        din_q   <= win ? wdata[DAT +: DAT] : wdata[0 +: DAT];
                        cs_q    <= 1'b1;
                        wen_q   <= we[win];
                        ren_q   <= ~we[win];
                    end
                end
                ACCESS: begin
                    state_q   <= RESP;
                    cs_q      <= 1'b0;
                    wen_q     <= 1'b0;
                    ren_q     <= 1'b0;
                    ack_q     <= win_q ? 2'b10 : 2'b01;
                    rd_resp_q <= ~we_q;
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    last_q  <= win_q;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cs_q    <= 1'b0;
                    wen_q   <= 1'b0;
                    ren_q   <= 1'b0;
                end
            endcase
        end
    end

    // SRAM read data is registered in the SRAM itself, so it is only gated here.
    assign rdata     = rd_resp_q ? sram_dout : '0;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign CS        = cs_q;
    assign WE        = wen_q;
    assign RD        = ren_q;
    assign sram_addr = addr_q;
    assign sram_din  = din_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table, directed corner cases, random traffic.
// Expectations follow SRAM_ARB_RR_EN when the bench is compiled with it.
module tb_sram_arbiter;

    localparam int unsigned ADR = 8;
    localparam int unsigned DAT = 8;

    logic             clk = 1'b0;
    logic             rst_n_r;
    logic [1:0]       req_r;
    logic [1:0]       we_r;
    logic [2*ADR-1:0] addr_r;
    logic [2*DAT-1:0] wdata_r;
    logic [1:0]       ack_s;
    logic [DAT-1:0]   rdata_s;
    logic             busy_s, cs_s, wen_s, ren_s;
    logic [ADR-1:0]   sram_addr_s;
    logic [DAT-1:0]   sram_din_s;
    bit   [DAT-1:0]   sram_dout_s;

    always #5 clk = ~clk;

    sram_arbiter #(.ADR(ADR), .DAT(DAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n_r),
        .req       (req_r),
        .we        (we_r),
        .addr      (addr_r),
        .wdata     (wdata_r),
        .ack       (ack_s),
        .rdata     (rdata_s),
        .busy      (busy_s),
        .CS        (cs_s),
        .WE        (wen_s),
        .RD        (ren_s),
        .sram_addr (sram_addr_s),
        .sram_din  (sram_din_s),
        .sram_dout (sram_dout_s)
    );

    // Behavioural SRAM with registered read port.
    bit [DAT-1:0] env_mem [256];
    always @(posedge clk) begin
        if (cs_s && wen_s) env_mem[sram_addr_s] <= sram_din_s;
        if (cs_s && ren_s) sram_dout_s <= env_mem[sram_addr_s];
    end

    // Transaction-level reference model.
    typedef struct {
        bit          valid;
        int unsigned start;
        bit          win;
        bit          we;
        logic [7:0]  adr;
        logic [7:0]  din;
        logic [7:0]  rd;
    } txn_t;

    typedef struct {
        logic [1:0] req;
        logic [1:0] we;
        logic [7:0] a0, a1, d0, d1;
        logic [1:0] ack;
        logic [7:0] rd;
    } vec_t;

    bit   [7:0]  model_mem [256];
    txn_t        cur;
    int unsigned cyc = 0;
    int unsigned next_free = 0;
    bit          last_srv = 1'b1;
    logic [7:0]  last_adr = '0;
    logic [7:0]  last_din = '0;
    int          total = 0;
    int          bad = 0;
    vec_t        vecs [6];
    logic [1:0]  ack_seen [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_cycle();
        int d;
        bit acc, rsp;
        d   = int'(cyc) - int'(cur.start);
        acc = cur.valid && (d == 1);
        rsp = cur.valid && (d == 2);
        chk("busy", 32'(busy_s), 32'(acc || rsp));
        chk("cs", 32'(cs_s), 32'(acc));
        chk("we_out", 32'(wen_s), 32'(acc && cur.we));
        chk("rd_out", 32'(ren_s), 32'(acc && !cur.we));
        chk("ack", 32'(ack_s), rsp ? (cur.win ? 32'd2 : 32'd1) : 32'd0);
        chk("rdata", 32'(rdata_s), (rsp && !cur.we) ? 32'(cur.rd) : 32'd0);
        chk("sram_addr", 32'(sram_addr_s), 32'(last_adr));
        chk("sram_din", 32'(sram_din_s), 32'(last_din));
    endtask

    // Predict the effect of the coming edge, advance one cycle, then check.
    task automatic step();
        bit w;
        if (!rst_n_r) begin
            cur.valid = 1'b0;
            next_free = cyc + 1;
            last_srv  = 1'b1;
            last_adr  = '0;
            last_din  = '0;
        end else begin
            if (cur.valid && cyc == cur.start + 2) last_srv = cur.win;
            if (cyc >= next_free && req_r != 2'b00) begin
                if (req_r == 2'b11) begin
`ifdef SRAM_ARB_RR_EN
                    w = ~last_srv;
`else
                    w = 1'b0;
`endif
                end else begin
                    w = (req_r == 2'b10);
                end
                cur.valid = 1'b1;
                cur.start = cyc;
                cur.win   = w;
                cur.we    = we_r[w];
                cur.adr   = w ? addr_r[15:8] : addr_r[7:0];
                cur.din   = w ? wdata_r[15:8] : wdata_r[7:0];
                cur.rd    = model_mem[cur.adr];
                if (cur.we) model_mem[cur.adr] = cur.din;
                next_free = cyc + 3;
                last_adr  = cur.adr;
                last_din  = cur.din;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic drive(input logic [1:0] rq, input logic [1:0] w,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
        req_r   = rq;
        we_r    = w;
        addr_r  = {a1, a0};
        wdata_r = {d1, d0};
    endtask

    initial begin
        vecs[0] = '{2'b01, 2'b01, 8'h05, 8'h00, 8'hA5, 8'h00, 2'b01, 8'h00};
        vecs[1] = '{2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00, 2'b01, 8'hA5};
        vecs[2] = '{2'b10, 2'b10, 8'h00, 8'h10, 8'h00, 8'h5A, 2'b10, 8'h00};
        vecs[3] = '{2'b11, 2'b00, 8'h10, 8'h05, 8'h00, 8'h00, 2'b01, 8'h5A};
`ifdef SRAM_ARB_RR_EN
        vecs[4] = '{2'b11, 2'b00, 8'h10, 8'h05, 8'h00, 8'h00, 2'b10, 8'hA5};
`else
        vecs[4] = '{2'b11, 2'b00, 8'h10, 8'h05, 8'h00, 8'h00, 2'b01, 8'h5A};
`endif
        vecs[5] = '{2'b10, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00, 2'b10, 8'h5A};

        // Reset for two cycles.
        rst_n_r = 1'b0;
        drive(2'b11, 2'b11, 8'h33, 8'h44, 8'h55, 8'h66);
        step();
        step();
        chk("reset_busy", 32'(busy_s), 32'd0);
        chk("reset_ack", 32'(ack_s), 32'd0);
        chk("reset_cs", 32'(cs_s), 32'd0);
        rst_n_r = 1'b1;
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        step();

        // Vector table: one transaction per row, req dropped once in ACCESS.
        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            step();
            chk("vec_cs", 32'(cs_s), 32'd1);
            chk("vec_we", 32'(wen_s), 32'(vecs[i].we[vecs[i].req == 2'b10 ? 1 : 0] && vecs[i].req != 2'b11));
            req_r = 2'b00;
            step();
            chk("vec_ack", 32'(ack_s), 32'(vecs[i].ack));
            chk("vec_rdata", 32'(rdata_s), 32'(vecs[i].rd));
            step();
        end

        // Held contention, both reads.
        drive(2'b11, 2'b00, 8'h10, 8'h05, 8'h00, 8'h00);
        for (int k = 0; k < 12; k++) begin
            step();
            if (ack_s != 2'b00) ack_seen.push_back(ack_s);
        end
        req_r = 2'b00;
        repeat (3) step();
        chk("cont_count", 32'(ack_seen.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] want;
`ifdef SRAM_ARB_RR_EN
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            want = 2'b01;
`endif
            chk("cont_ack", (k < ack_seen.size()) ? 32'(ack_seen[k]) : 32'hFFFF, 32'(want));
        end

        // Early drop of req0 during ACCESS.
        drive(2'b01, 2'b01, 8'h22, 8'h00, 8'h77, 8'h00);
        step();
        req_r = 2'b00;
        step();
        chk("drop_ack", 32'(ack_s), 32'd1);
        repeat (3) step();
        chk("drop_idle_busy", 32'(busy_s), 32'd0);
        chk("drop_idle_cs", 32'(cs_s), 32'd0);

        // Reset while in ACCESS, then a normal request from requester 1.
        drive(2'b01, 2'b00, 8'h22, 8'h00, 8'h00, 8'h00);
        step();
        rst_n_r = 1'b0;
        req_r   = 2'b00;
        step();
        chk("rst_mid_ack", 32'(ack_s), 32'd0);
        chk("rst_mid_cs", 32'(cs_s), 32'd0);
        rst_n_r = 1'b1;
        step();
        chk("rst_mid_noack", 32'(ack_s), 32'd0);
        drive(2'b10, 2'b00, 8'h00, 8'h22, 8'h00, 8'h00);
        step();
        req_r = 2'b00;
        step();
        chk("rst_after_ack", 32'(ack_s), 32'd2);
        chk("rst_after_rdata", 32'(rdata_s), 32'h77);
        step();

        // Random traffic over a small address window.
        for (int k = 0; k < 400; k++) begin
            rst_n_r = ($urandom_range(0, 49) != 0);
            drive(2'($urandom), 2'($urandom),
                  8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                  8'($urandom), 8'($urandom));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADR, default 8, meaning SRAM address width.
REQ-002 SHALL have parameter DAT, default 8, meaning SRAM data width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req  input  2  per-requester access request; bit i belongs to requester i.
REQ-006 SHALL have port we  input  2  per-requester operation select: 1 = write, 0 = read.
REQ-007 SHALL have port addr  input  2*ADR  per-requester address; requester i uses slice [i*ADR +: ADR].
REQ-008 SHALL have port wdata  input  2*DAT  per-requester write data; requester i uses slice [i*DAT +: DAT].
REQ-009 SHALL have port ack  output  2  one-cycle completion pulse per requester.
REQ-010 SHALL have port rdata  output  DAT  read data, valid only while the matching ack bit is 1 and the operation is a read.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port CS, WE, RD  outputs  1 each  SRAM chip select, write enable, read enable.
REQ-013 SHALL have port sram_addr  output  ADR  and port sram_din  output  DAT  SRAM address and write data.
REQ-014 SHALL have port sram_dout  input  DAT  SRAM registered read data, updated one edge after a read access.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS when any req bit is 1, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-016 SHALL, at the IDLE->ACCESS edge, register the winner index, that requester's we, address slice and wdata slice; later changes to requester inputs SHALL NOT affect the transaction.
REQ-017 SHALL drive CS=1, WE=latched we and RD=~latched we from registers during ACCESS only; in IDLE and RESP, CS=WE=RD=0.
REQ-018 SHALL drive sram_addr/sram_din from the latched values; they hold their last value outside ACCESS.
REQ-019 SHALL, in RESP, assert ack[winner]=1 and ack[other]=0; for reads, rdata SHALL equal sram_dout during that cycle; rdata otherwise SHALL be 0.
REQ-020 SHALL give a fixed latency of 3 cycles from a req sampled in IDLE to the end of its ack cycle, with at most one transaction per 3 cycles.
REQ-021 SHALL treat req as level-sensitive: req held high after ack starts a new transaction at the next IDLE; a requester wanting one access SHALL drop req in its ack cycle.
REQ-022 SHALL complete an accepted transaction and pulse ack even if req drops during ACCESS or RESP.
REQ-023 SHALL, when both req bits are 1 in IDLE, grant per arbitration policy (REQ-028/029); single req SHALL always be granted.
REQ-024 SHALL update a last-served pointer to the winner at the RESP->IDLE edge.

Reset
REQ-025 SHALL, on rst_n=0 at a posedge, enter IDLE and set ack=0, rdata=0, busy=0, CS=WE=RD=0, sram_addr=0, sram_din=0, last-served pointer=1.
REQ-026 SHALL abandon an in-flight transaction on reset without any ack; an SRAM write already issued in ACCESS is not rolled back.

Configuration
REQ-027 SHALL use macro SRAM_ARB_RR_EN to select the arbitration policy.
REQ-028 SHALL, with SRAM_ARB_RR_EN defined, arbitrate round-robin: on contention, grant the requester that is not the last-served one.
REQ-029 SHALL, without SRAM_ARB_RR_EN, arbitrate fixed-priority with requester 0 always winning contention; the pointer may be omitted.

Structure
REQ-030 SHALL place the state enum (IDLE, ACCESS, RESP) and the default ADR/DAT constants in shared package sram_arb_pkg.
REQ-031 SHALL implement the grant decision in one sub-module sram_arb_pick (inputs: req, last-served; output: winner index).

Verification
REQ-032 Reset: rst_n=0 for 2 cycles -> all outputs 0, busy=0, state IDLE.
REQ-033 Single write/read: req=01, we=01, addr0=8'h05, wdata0=8'hA5 -> CS=WE=1 in cycle 2, ack=01 in cycle 3; then read of 8'h05 -> rdata=8'hA5 with ack=01.
REQ-034 Contention: req=11 held, both reads -> with SRAM_ARB_RR_EN, ack sequence 01,10,01,10; without it, ack always 01.
REQ-035 Early drop: req0 dropped during ACCESS -> ack0 still pulses in RESP, no second transaction.
REQ-036 Reset mid-operation: rst_n=0 during ACCESS -> no ack, next cycle IDLE with CS=0; subsequent req=10 served normally with ack=10 after 3 cycles.
